// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single DataMemory port between the CPU load/store path (port C)
// and a debug / program-loader master (port D). Arbitration is round-robin
// with a bounded-burst fairness counter: while both ports are requesting, the
// current owner may keep the port for at most MAX_BURST consecutive accepts
// before the other port gets a turn.
//
// Commands to memory are registered (one cycle after accept). Read data is
// captured in the cycle the read strobe is high and returned one cycle later
// on the issuing port together with a one-cycle rvalid pulse.
//
// Optional feature: define DMEM_ARB_PERF_EN to add saturating 32-bit
// performance counters (perf_c_grants, perf_d_grants, perf_conflicts).
//
// Ports:
//   CLK, reset                  clock, synchronous active-high reset
//   c_valid/c_write/c_addr/c_wdata  CPU request; c_ready = accepted this cycle
//   c_rdata/c_rvalid            CPU load return
//   d_*                         same set for the debug port
//   MemoryRead/MemoryWrite      registered strobes to DataMemory
//   Address/WriteData           registered command address / store data
//   ReadData                    DataMemory data, valid while MemoryRead is high
//   perf_* (DMEM_ARB_PERF_EN)   accept and conflict counters
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 4
) (
    input  logic              CLK,
    input  logic              reset,
    // CPU port
    input  logic              c_valid,
    input  logic              c_write,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ready,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_rvalid,
    // Debug port
    input  logic              d_valid,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    // DataMemory side
    output logic              MemoryRead,
    output logic              MemoryWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_c_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflicts
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_C = 2'd1,
        OWN_D = 2'd2
    } state_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t      state_reg, state_next;
    logic [3:0]  burst_reg, burst_next;
    logic        rr_d_reg, rr_d_next;     // 1: round-robin pointer at port D

    logic        gnt_c, gnt_d;

    // Registered memory command
    logic              mem_rd_reg, mem_wr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              tag_d_reg;          // issuing port of the command in flight

    // Read return
    logic              c_rvalid_reg, d_rvalid_reg;
    logic [DATA_W-1:0] c_rdata_reg, d_rdata_reg;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg <= IDLE;
            burst_reg <= 4'd0;
            rr_d_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            burst_reg <= burst_next;
            rr_d_reg  <= rr_d_next;
        end
    end

    // -------------------------------------------------------------------------
    // Grant. Gated by reset so a requester never sees an accept that the
    // reset would then discard.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
        if (!reset) begin
            if (c_valid && !d_valid) begin
                gnt_c = 1'b1;
            end else if (d_valid && !c_valid) begin
                gnt_d = 1'b1;
            end else if (c_valid && d_valid) begin
                case (state_reg)
                    OWN_C: begin
                        if (burst_reg < MAX_B) gnt_c = 1'b1;
                        else                   gnt_d = 1'b1;
                    end
                    OWN_D: begin
                        if (burst_reg < MAX_B) gnt_d = 1'b1;
                        else                   gnt_c = 1'b1;
                    end
                    default: begin
                        if (rr_d_reg) gnt_d = 1'b1;
                        else          gnt_c = 1'b1;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. The burst counter only keeps growing while the same
    // owner wins against a requesting competitor; an uncontested accept or an
    // owner change restarts it at 1.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        burst_next = burst_reg;
        rr_d_next  = rr_d_reg;
        if (gnt_c) begin
            state_next = OWN_C;
            rr_d_next  = 1'b1;
            if (state_reg != OWN_C || !d_valid) burst_next = 4'd1;
            else if (burst_reg < MAX_B)         burst_next = burst_reg + 4'd1;
        end else if (gnt_d) begin
            state_next = OWN_D;
            rr_d_next  = 1'b0;
            if (state_reg != OWN_D || !c_valid) burst_next = 4'd1;
            else if (burst_reg < MAX_B)         burst_next = burst_reg + 4'd1;
        end else begin
            state_next = IDLE;
            burst_next = 4'd0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        c_ready     = gnt_c;
        d_ready     = gnt_d;
        MemoryRead  = mem_rd_reg;
        MemoryWrite = mem_wr_reg;
        Address     = addr_reg;
        WriteData   = wdata_reg;
        c_rvalid    = c_rvalid_reg;
        d_rvalid    = d_rvalid_reg;
        c_rdata     = c_rdata_reg;
        d_rdata     = d_rdata_reg;
    end

    // -------------------------------------------------------------------------
    // Command register. Address/WriteData hold their last value between
    // commands; only the strobes are single-cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            mem_rd_reg <= 1'b0;
            mem_wr_reg <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            tag_d_reg  <= 1'b0;
        end else begin
            mem_rd_reg <= (gnt_c && !c_write) || (gnt_d && !d_write);
            mem_wr_reg <= (gnt_c &&  c_write) || (gnt_d &&  d_write);
            if (gnt_c) begin
                addr_reg  <= c_addr;
                wdata_reg <= c_wdata;
                tag_d_reg <= 1'b0;
            end else if (gnt_d) begin
                addr_reg  <= d_addr;
                wdata_reg <= d_wdata;
                tag_d_reg <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read return: ReadData is sampled while the read strobe is high and
    // steered to the issuing port.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            c_rvalid_reg <= 1'b0;
            d_rvalid_reg <= 1'b0;
            c_rdata_reg  <= '0;
            d_rdata_reg  <= '0;
        end else begin
            c_rvalid_reg <= mem_rd_reg && !tag_d_reg;
            d_rvalid_reg <= mem_rd_reg &&  tag_d_reg;
            if (mem_rd_reg && !tag_d_reg) c_rdata_reg <= ReadData;
            if (mem_rd_reg &&  tag_d_reg) d_rdata_reg <= ReadData;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    // -------------------------------------------------------------------------
    // Saturating performance counters: [0] C accepts, [1] D accepts,
    // [2] cycles with both ports requesting.
    // -------------------------------------------------------------------------
    logic [2:0]       perf_inc;
    logic [2:0][31:0] perf_all;

    assign perf_inc = {c_valid && d_valid, gnt_d, gnt_c};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            logic [31:0] cnt_reg;
            always_ff @(posedge CLK) begin
                if (reset)
                    cnt_reg <= '0;
                else if (perf_inc[gi] && cnt_reg != 32'hFFFF_FFFF)
                    cnt_reg <= cnt_reg + 32'd1;
            end
            assign perf_all[gi] = cnt_reg;
        end
    endgenerate

    assign perf_c_grants  = perf_all[0];
    assign perf_d_grants  = perf_all[1];
    assign perf_conflicts = perf_all[2];
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter. A transaction-level model tracks the
// last owner, its run length and the round-robin pointer, predicts every
// grant, the memory command one cycle after each accept and the read return
// one cycle after that. Directed sequences pin the model with literal values,
// then randomized request traffic with occasional resets runs against it.
// Build with +define+DMEM_ARB_PERF_EN to also check the counters.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int MAXB = 4;

    logic        CLK;
    logic        reset;
    logic        c_valid, c_write, c_ready, c_rvalid;
    logic [63:0] c_addr, c_wdata, c_rdata;
    logic        d_valid, d_write, d_ready, d_rvalid;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic        MemoryRead, MemoryWrite;
    logic [63:0] Address, WriteData, ReadData;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_c_grants, perf_d_grants, perf_conflicts;
`endif

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_BURST(MAXB)) dut (
        .CLK(CLK), .reset(reset),
        .c_valid(c_valid), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ready(c_ready), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
        .d_valid(d_valid), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
`ifdef DMEM_ARB_PERF_EN
        , .perf_c_grants(perf_c_grants), .perf_d_grants(perf_d_grants),
        .perf_conflicts(perf_conflicts)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Pending requests held by the bench-side requesters
    bit          cp, dp;
    bit          cw, dw;
    logic [63:0] ca, cwd, da, dwd;

    // Arbitration model: 0 = none, 1 = C, 2 = D
    int last_own, streak, rr;

    // Expected outputs for the current cycle
    bit          exp_rd, exp_wr, exp_addr_known;
    logic [63:0] exp_addr, exp_wd;
    int          exp_tag;
    bit          exp_crv, exp_drv;
    logic [63:0] exp_crd, exp_drd;
    longint      m_cg, m_dg, m_cf;

    // Observed values of the last step, for literal checks
    int          obs_gnt;
    logic        obs_mr, obs_mw, obs_crv, obs_drv;
    logic [63:0] obs_addr, obs_wd, obs_crd, obs_drd;
    logic [31:0] obs_pc, obs_pd, obs_pf;

    // Memory contents seen by the arbiter (a few fixed locations, else a hash)
    function automatic logic [63:0] rd_fn(input logic [63:0] a);
        if (a == 64'h10) return 64'hDEAD;
        if (a == 64'h0)  return 64'h11;
        if (a == 64'h8)  return 64'h22;
        return {a[31:0] ^ 32'h5A5A_1234, a[63:32]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Who must win this cycle, from the fairness rules
    function automatic int model_grant(input bit cv, input bit dv);
        if (cv && !dv) return 1;
        if (dv && !cv) return 2;
        if (!cv && !dv) return 0;
        if (last_own == 0) return rr;
        if (streak < MAXB) return last_own;
        return 3 - last_own;
    endfunction

    task automatic model_reset();
        last_own = 0; streak = 0; rr = 1;
        exp_rd = 0; exp_wr = 0; exp_addr = '0; exp_wd = '0; exp_tag = 1;
        exp_addr_known = 1;
        exp_crv = 0; exp_drv = 0; exp_crd = '0; exp_drd = '0;
        m_cg = 0; m_dg = 0; m_cf = 0;
    endtask

    task automatic req_c(input bit w, input logic [63:0] a, input logic [63:0] wd);
        cp = 1; cw = w; ca = a; cwd = wd;
    endtask

    task automatic req_d(input bit w, input logic [63:0] a, input logic [63:0] wd);
        dp = 1; dw = w; da = a; dwd = wd;
    endtask

    // One clock cycle: drive requests, compare every output, advance the model
    task automatic step(input bit do_reset);
        int g;
        bit other_v;
        @(posedge CLK);
        #1;
        reset   = do_reset;
        c_valid = cp; c_write = cw; c_addr = ca; c_wdata = cwd;
        d_valid = dp; d_write = dw; d_addr = da; d_wdata = dwd;
        ReadData = MemoryRead ? rd_fn(Address) : {$urandom, $urandom};
        #1;
        g = do_reset ? 0 : model_grant(cp, dp);

        obs_gnt  = c_ready ? 1 : (d_ready ? 2 : 0);
        obs_mr   = MemoryRead;  obs_mw  = MemoryWrite;
        obs_addr = Address;     obs_wd  = WriteData;
        obs_crv  = c_rvalid;    obs_crd = c_rdata;
        obs_drv  = d_rvalid;    obs_drd = d_rdata;

        chk("c_ready", 64'(c_ready), 64'(g == 1));
        chk("d_ready", 64'(d_ready), 64'(g == 2));
        chk("MemoryRead", 64'(MemoryRead), 64'(exp_rd));
        chk("MemoryWrite", 64'(MemoryWrite), 64'(exp_wr));
        if (exp_addr_known) chk("Address", Address, exp_addr);
        if (exp_wr || exp_addr_known && !exp_rd) chk("WriteData", WriteData, exp_wd);
        chk("c_rvalid", 64'(c_rvalid), 64'(exp_crv));
        chk("d_rvalid", 64'(d_rvalid), 64'(exp_drv));
        chk("c_rdata", c_rdata, exp_crd);
        chk("d_rdata", d_rdata, exp_drd);
`ifdef DMEM_ARB_PERF_EN
        obs_pc = perf_c_grants; obs_pd = perf_d_grants; obs_pf = perf_conflicts;
        chk("perf_c_grants", 64'(perf_c_grants), 64'(m_cg));
        chk("perf_d_grants", 64'(perf_d_grants), 64'(m_dg));
        chk("perf_conflicts", 64'(perf_conflicts), 64'(m_cf));
`else
        obs_pc = '0; obs_pd = '0; obs_pf = '0;
`endif

        if (do_reset) begin
            model_reset();
            cp = 0; dp = 0;
        end else begin
            // Read issued last cycle comes back next cycle on its port
            exp_crv = exp_rd && exp_tag == 1;
            exp_drv = exp_rd && exp_tag == 2;
            if (exp_crv) exp_crd = rd_fn(exp_addr);
            if (exp_drv) exp_drd = rd_fn(exp_addr);
            if (cp && dp) m_cf++;
            if (g != 0) begin
                exp_wr   = (g == 1) ? cw : dw;
                exp_rd   = !exp_wr;
                exp_addr = (g == 1) ? ca : da;
                exp_wd   = (g == 1) ? cwd : dwd;
                exp_tag  = g;
                exp_addr_known = 1;
                other_v  = (g == 1) ? dp : cp;
                if (g != last_own || !other_v) streak = 1;
                else if (streak < MAXB)        streak = streak + 1;
                last_own = g;
                rr = 3 - g;
                if (g == 1) begin cp = 0; m_cg++; end
                else        begin dp = 0; m_dg++; end
            end else begin
                exp_rd = 0; exp_wr = 0; exp_addr_known = 0;
                last_own = 0; streak = 0;
            end
        end
        $display("cyc rst=%0d cv=%0d dv=%0d grant=%0d mr=%0d mw=%0d addr=%h crv=%0d drv=%0d",
                 do_reset, c_valid, d_valid, obs_gnt, obs_mr, obs_mw, obs_addr, obs_crv, obs_drv);
    endtask

    initial begin
        int exp_seq [12] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};

        reset = 1; ReadData = '0;
        c_valid = 0; c_write = 0; c_addr = '0; c_wdata = '0;
        d_valid = 0; d_write = 0; d_addr = '0; d_wdata = '0;
        cp = 0; dp = 0; cw = 0; dw = 0; ca = '0; da = '0; cwd = '0; dwd = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        step(1);
        chk("reset_Address", obs_addr, 64'h0);
        chk("reset_c_rdata", obs_crd, 64'h0);

        // Port C load from 0x10
        step(1);
        req_c(0, 64'h10, 64'h0);
        step(0);
        chk("t1_c_ready", 64'(obs_gnt), 64'd1);
        step(0);
        chk("t1_MemoryRead", 64'(obs_mr), 64'd1);
        chk("t1_Address", obs_addr, 64'h10);
        step(0);
        chk("t1_c_rvalid", 64'(obs_crv), 64'd1);
        chk("t1_c_rdata", obs_crd, 64'hDEAD);
        chk("t1_d_rvalid", 64'(obs_drv), 64'd0);

        // Both ports requesting continuously from reset
        step(1);
        for (int i = 0; i < 12; i++) begin
            if (!cp) req_c(0, 64'h1000 + 64'(i) * 8, 64'h0);
            if (!dp) req_d(0, 64'h2000 + 64'(i) * 8, 64'h0);
            step(0);
            chk($sformatf("t2_grant%0d", i), 64'(obs_gnt), 64'(exp_seq[i]));
        end
        cp = 0; dp = 0;
        step(1);

        // Store on D
        req_d(1, 64'h20, 64'h5A);
        step(0);
        chk("t3_d_ready", 64'(obs_gnt), 64'd2);
        step(0);
        chk("t3_MemoryWrite", 64'(obs_mw), 64'd1);
        chk("t3_Address", obs_addr, 64'h20);
        chk("t3_WriteData", obs_wd, 64'h5A);
        step(0);
        chk("t3_no_rvalid", 64'({obs_crv, obs_drv}), 64'd0);

        // Back-to-back reads C@0 then D@8
        req_c(0, 64'h0, 64'h0);
        step(0);
        req_d(0, 64'h8, 64'h0);
        step(0);
        step(0);
        chk("t4_c_rvalid", 64'(obs_crv), 64'd1);
        chk("t4_c_rdata", obs_crd, 64'h11);
        step(0);
        chk("t4_d_rvalid", 64'(obs_drv), 64'd1);
        chk("t4_d_rdata", obs_drd, 64'h22);

        // Reset the cycle after a C load is accepted
        req_c(0, 64'h30, 64'h0);
        step(0);
        step(1);
        chk("t5_mr_before", 64'(obs_mr), 64'd1);
        step(0);
        chk("t5_MemoryRead", 64'(obs_mr), 64'd0);
        chk("t5_c_rvalid", 64'(obs_crv), 64'd0);
        step(0);
        chk("t5_c_rvalid_late", 64'(obs_crv), 64'd0);

`ifdef DMEM_ARB_PERF_EN
        // Ten conflict cycles
        step(1);
        for (int i = 0; i < 10; i++) begin
            if (!cp) req_c(0, 64'h3000 + 64'(i), 64'h0);
            if (!dp) req_d(1, 64'h4000 + 64'(i), 64'(i));
            step(0);
        end
        cp = 0; dp = 0;
        step(0);
        chk("t6_conflicts", 64'(obs_pf), 64'd10);
        chk("t6_grant_sum", 64'(obs_pc) + 64'(obs_pd), 64'd10);
        step(1);
        step(0);
        chk("t6_reset_cnt", 64'({obs_pc, obs_pd}) | 64'(obs_pf), 64'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!cp && ($urandom % 4) != 0)
                req_c(1'($urandom % 2), {$urandom, $urandom}, {$urandom, $urandom});
            if (!dp && ($urandom % 3) == 0)
                req_d(1'($urandom % 2), {$urandom, $urandom}, {$urandom, $urandom});
            step(($urandom % 150) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
